// File: rtl/uart_pkg.sv
// Shared types and constants for the parametrised UART receiver.
package uart_pkg;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    EVEN = 2'd1,
    ODD  = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_e;

  localparam int UART_MIN_BAUD = 4;

  // Both 00 and 11 on the mode pins mean no parity bit on the line.
  function automatic parity_e decode_parity(input logic [1:0] mode);
    case (mode)
      2'b01:   decode_parity = EVEN;
      2'b10:   decode_parity = ODD;
      default: decode_parity = NONE;
    endcase
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period down-counter: half-period preload on start, then one sample tick every N cycles.
// UART_RX_MAJORITY_EN adds pre/post ticks one cycle either side of each sample tick.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int BAUD_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              run_i,
  input  logic [BAUD_W-1:0] period_i,
`ifdef UART_RX_MAJORITY_EN
  output logic              pre_tick_o,
  output logic              post_tick_o,
`endif
  output logic              sample_tick_o
);

  localparam logic [BAUD_W-1:0] MIN_N = BAUD_W'(UART_MIN_BAUD);
  localparam logic [BAUD_W-1:0] ONE   = BAUD_W'(1);

  logic [BAUD_W-1:0] clamped;
  logic [BAUD_W-1:0] period_q;
  logic [BAUD_W-1:0] cnt_q;

  assign clamped       = (period_i < MIN_N) ? MIN_N : period_i;
  assign sample_tick_o = run_i && (cnt_q == '0);

  // The period is frozen at frame start so a mid-frame baudrate change has no effect.
  always_ff @(posedge clk) begin
    if (rst) begin
      period_q <= MIN_N;
      cnt_q    <= '0;
    end else if (start_i) begin
      period_q <= clamped;
      cnt_q    <= (clamped >> 1) - ONE;
    end else if (run_i) begin
      cnt_q <= (cnt_q == '0) ? (period_q - ONE) : (cnt_q - ONE);
    end
  end

`ifdef UART_RX_MAJORITY_EN
  logic post_q;

  assign pre_tick_o  = run_i && (cnt_q == ONE);
  assign post_tick_o = post_q;

  always_ff @(posedge clk) begin
    if (rst || start_i) begin
      post_q <= 1'b0;
    end else begin
      post_q <= sample_tick_o;
    end
  end
`endif

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: synchroniser, frame FSM, parity/framing checks, valid/ready output.
// UART_RX_MAJORITY_EN selects 2-of-3 majority sampling (decisions one cycle later).
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int BAUD_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dataline,
  input  logic [BAUD_W-1:0] baudrate,
  input  logic [1:0]        parity_mode,
  input  logic              stop2,
  output logic [DATA_W-1:0] data,
  output logic              valid,
  input  logic              ready,
  output logic              parity_err,
  output logic              frame_err,
  output logic              overrun,
  output logic              busy,
  output rx_state_e         state_dbg
);

  // Output handshake: a word is transferred on any rising edge where valid && ready;
  // valid stays high and data/flags stay stable until that edge.

  localparam logic [3:0] CNT_LAST = 4'(DATA_W - 1);

  logic              sync1_q, rxs_q;
  rx_state_e         state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  parity_e           par_q, par_d;
  logic              stop2_q, stop2_d;
  logic              perr_q, perr_d, ferr_q, ferr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d, pe_q, pe_d, fe_q, fe_d, ovr_q, ovr_d;
  logic              start, complete, accept, tick, bit_val, sample_tick;

`ifdef UART_RX_MAJORITY_EN
  logic       pre_tick, post_tick;
  logic [1:0] vote_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      vote_q <= 2'b11;
    end else begin
      if (pre_tick)    vote_q[0] <= rxs_q;
      if (sample_tick) vote_q[1] <= rxs_q;
    end
  end

  assign tick    = post_tick;
  assign bit_val = (vote_q[0] & vote_q[1]) | (vote_q[0] & rxs_q) | (vote_q[1] & rxs_q);
`else
  assign tick    = sample_tick;
  assign bit_val = rxs_q;
`endif

  uart_baud_gen #(.BAUD_W(BAUD_W)) u_baud (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start),
    .run_i        (busy),
    .period_i     (baudrate),
`ifdef UART_RX_MAJORITY_EN
    .pre_tick_o   (pre_tick),
    .post_tick_o  (post_tick),
`endif
    .sample_tick_o(sample_tick)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    par_d    = par_q;
    stop2_d  = stop2_q;
    perr_d   = perr_q;
    ferr_d   = ferr_q;
    start    = 1'b0;
    complete = 1'b0;
    case (state_q)
      IDLE: if (!rxs_q) begin
        state_d = START;
        start   = 1'b1;
        par_d   = decode_parity(parity_mode);
        stop2_d = stop2;
        cnt_d   = 4'd0;
        perr_d  = 1'b0;
        ferr_d  = 1'b0;
      end
      START: if (tick) state_d = bit_val ? IDLE : DATA;
      DATA: if (tick) begin
        shift_d = {bit_val, shift_q[DATA_W-1:1]};
        if (cnt_q == CNT_LAST) begin
          cnt_d   = 4'd0;
          state_d = (par_q == NONE) ? STOP : PARITY;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      PARITY: if (tick) begin
        perr_d  = (par_q == EVEN) ? ((^shift_q) ^ bit_val) : ~((^shift_q) ^ bit_val);
        state_d = STOP;
      end
      STOP: if (tick) begin
        ferr_d = ferr_q | ~bit_val;
        if (cnt_q == {3'b000, stop2_q}) begin
          complete = 1'b1;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A completion coinciding with an accept refills the slot instead of overrunning.
  always_comb begin
    accept  = valid_q && ready;
    data_d  = data_q;
    pe_d    = pe_q;
    fe_d    = fe_q;
    valid_d = valid_q;
    if (complete && (!valid_q || accept)) begin
      data_d  = shift_q;
      pe_d    = perr_q;
      fe_d    = ferr_d;
      valid_d = 1'b1;
    end else if (accept) begin
      valid_d = 1'b0;
    end
    ovr_d = accept ? 1'b0 : ((complete && valid_q) ? 1'b1 : ovr_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      rxs_q   <= 1'b1;
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      shift_q <= '0;
      par_q   <= NONE;
      stop2_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      pe_q    <= 1'b0;
      fe_q    <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      sync1_q <= dataline;
      rxs_q   <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      stop2_q <= stop2_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      pe_q    <= pe_d;
      fe_q    <= fe_d;
      ovr_q   <= ovr_d;
    end
  end

  assign data       = data_q;
  assign valid      = valid_q;
  assign parity_err = pe_q;
  assign frame_err  = fe_q;
  assign overrun    = ovr_q;
  assign busy       = (state_q != IDLE);
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: an 8-bit and a 7-bit receiver driven by serial frame tasks,
// words checked against an expected queue of {frame_err, parity_err, data}.
module tb_uart_rx_param;
  import uart_pkg::*;

`ifdef UART_RX_MAJORITY_EN
  localparam int MAJ = 1;
`else
  localparam int MAJ = 0;
`endif

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst;
  logic        line8, line7, ready8, ready7, stop2_8, stop2_7;
  logic [15:0] baud8, baud7;
  logic [1:0]  pm8, pm7;
  logic [7:0]  data8;
  logic [6:0]  data7;
  logic        valid8, perr8, ferr8, ovr8, busy8;
  logic        valid7, perr7, ferr7, ovr7, busy7;
  rx_state_e   st8, st7;

  uart_rx_param #(.DATA_W(8), .BAUD_W(16)) u_dut8 (
    .clk(clk), .rst(rst), .dataline(line8), .baudrate(baud8), .parity_mode(pm8),
    .stop2(stop2_8), .data(data8), .valid(valid8), .ready(ready8), .parity_err(perr8),
    .frame_err(ferr8), .overrun(ovr8), .busy(busy8), .state_dbg(st8)
  );

  uart_rx_param #(.DATA_W(7), .BAUD_W(16)) u_dut7 (
    .clk(clk), .rst(rst), .dataline(line7), .baudrate(baud7), .parity_mode(pm7),
    .stop2(stop2_7), .data(data7), .valid(valid7), .ready(ready7), .parity_err(perr7),
    .frame_err(ferr7), .overrun(ovr7), .busy(busy7), .state_dbg(st7)
  );

  // scoreboard
  logic [10:0] exp_q[$];
  logic [10:0] exp7_q[$];
  int total = 0;
  int bad = 0;
  int start_cyc = 0;
  int rise_cyc = 0;
  int hi_len = 0;
  logic prev_v8 = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [10:0] e;
    if (!rst) begin
      if (valid8 && !prev_v8) begin
        rise_cyc = cyc;
        hi_len   = 0;
      end
      if (valid8) hi_len++;
      prev_v8 = valid8;
      if (valid8 && ready8) begin
        chk("pop8_avail", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("data8", 32'(data8), 32'(e[8:0]));
          chk("perr8", 32'(perr8), 32'(e[9]));
          chk("ferr8", 32'(ferr8), 32'(e[10]));
        end
      end
      if (valid7 && ready7) begin
        chk("pop7_avail", 32'(exp7_q.size() != 0), 1);
        if (exp7_q.size() != 0) begin
          e = exp7_q.pop_front();
          chk("data7", 32'(data7), 32'(e[8:0]));
          chk("perr7", 32'(perr7), 32'(e[9]));
          chk("ferr7", 32'(ferr7), 32'(e[10]));
        end
      end
    end
  end

  // driver tasks (called at a falling edge, return at a falling edge)
  task automatic idle(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic drive(input bit to7, input logic v);
    if (to7) line7 = v;
    else line8 = v;
  endtask

  task automatic send(input bit to7, input int n, input int dw, input logic [8:0] d,
                      input int pm, input bit flip, input bit two_stop, input bit stop2_low);
    logic pb;
    drive(to7, 1'b0);
    start_cyc = cyc;
    idle(n);
    pb = 1'b0;
    for (int i = 0; i < dw; i++) begin
      drive(to7, d[i]);
      pb = pb ^ d[i];
      idle(n);
    end
    if (pm != 0) begin
      if (pm == 2) pb = ~pb;
      if (flip) pb = ~pb;
      drive(to7, pb);
      idle(n);
    end
    drive(to7, 1'b1);
    idle(n);
    if (two_stop) begin
      drive(to7, ~stop2_low);
      idle(n);
      drive(to7, 1'b1);
    end
  endtask

  initial begin
    int c;
    rst = 1'b1; line8 = 1'b1; line7 = 1'b1; ready8 = 1'b1; ready7 = 1'b1;
    baud8 = 16'd8; pm8 = 2'b01; stop2_8 = 1'b0;
    baud7 = 16'd8; pm7 = 2'b10; stop2_7 = 1'b1;
    idle(3);
    chk("rst_data", 32'(data8), 0);
    chk("rst_valid", 32'(valid8), 0);
    chk("rst_perr", 32'(perr8), 0);
    chk("rst_ferr", 32'(ferr8), 0);
    chk("rst_ovr", 32'(ovr8), 0);
    chk("rst_busy", 32'(busy8), 0);
    rst = 1'b0;
    idle(2);

    // basic even-parity frame and its latency
    exp_q.push_back({1'b0, 1'b0, 9'h055});
    send(0, 8, 8, 9'h055, 1, 0, 0, 0);
    idle(10);
    chk("latency", 32'(rise_cyc - start_cyc), 32'(87 + MAJ));
    chk("valid_len", 32'(hi_len), 1);

    // back-to-back, first with a bad parity bit
    exp_q.push_back({1'b0, 1'b1, 9'h055});
    exp_q.push_back({1'b0, 1'b0, 9'h00F});
    send(0, 8, 8, 9'h055, 1, 1, 0, 0);
    send(0, 8, 8, 9'h00F, 1, 0, 0, 0);
    idle(10);

    // 7-bit odd parity, two stop bits; then second stop bit low
    exp7_q.push_back({1'b0, 1'b0, 9'h041});
    send(1, 8, 7, 9'h041, 2, 0, 1, 0);
    idle(10);
    exp7_q.push_back({1'b1, 1'b0, 9'h041});
    send(1, 8, 7, 9'h041, 2, 0, 1, 1);
    idle(40);

    // 3-cycle glitch is a false start
    line8 = 1'b0;
    c = cyc;
    idle(3);
    line8 = 1'b1;
    idle(3 + MAJ);
    chk("glitch_busy_hi", 32'(busy8), 1);
    chk("glitch_cyc", 32'(cyc - c), 32'(6 + MAJ));
    idle(1);
    chk("glitch_busy_lo", 32'(busy8), 0);
    idle(20);
    chk("glitch_novalid", 32'(valid8), 0);

    // overrun with the consumer stalled
    ready8 = 1'b0;
    exp_q.push_back({1'b0, 1'b0, 9'h0A5});
    send(0, 8, 8, 9'h0A5, 1, 0, 0, 0);
    send(0, 8, 8, 9'h03C, 1, 0, 0, 0);
    idle(4);
    chk("ovr_data", 32'(data8), 32'h0A5);
    chk("ovr_valid", 32'(valid8), 1);
    chk("ovr_flag", 32'(ovr8), 1);
    @(posedge clk);
    #1 ready8 = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("ovr_valid_clr", 32'(valid8), 0);
    chk("ovr_flag_clr", 32'(ovr8), 0);
    idle(4);

    // reset in the middle of the data bits with a word still pending
    ready8 = 1'b0;
    exp_q.push_back({1'b0, 1'b0, 9'h096});
    send(0, 8, 8, 9'h096, 1, 0, 0, 0);
    idle(4);
    chk("pre_rst_valid", 32'(valid8), 1);
    pm8 = 2'b00;
    fork
      send(0, 8, 8, 9'h0FF, 0, 0, 0, 0);
      begin
        idle(40);
        chk("pre_rst_busy", 32'(busy8), 1);
        rst = 1'b1;
        exp_q.delete();
        idle(1);
        chk("mid_rst_data", 32'(data8), 0);
        chk("mid_rst_valid", 32'(valid8), 0);
        chk("mid_rst_perr", 32'(perr8), 0);
        chk("mid_rst_ferr", 32'(ferr8), 0);
        chk("mid_rst_ovr", 32'(ovr8), 0);
        chk("mid_rst_busy", 32'(busy8), 0);
        rst = 1'b0;
      end
    join
    idle(30);
    chk("post_rst_noword", 32'(valid8), 0);
    ready8 = 1'b1;

    // baudrate below the minimum runs at 4 clocks per bit
    baud8 = 16'd2;
    pm8 = 2'b01;
    exp_q.push_back({1'b0, 1'b0, 9'h03C});
    send(0, 4, 8, 9'h03C, 1, 0, 0, 0);
    idle(20);

    chk("drain8", 32'(exp_q.size()), 0);
    chk("drain7", 32'(exp7_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_param.md
# uart_rx_param

Parametrised UART receiver for serial-to-parallel conversion on the system clock. It supports configurable data width, runtime parity mode, runtime stop-bit count and a programmable clocks-per-bit divisor. Received words are delivered on a valid/ready handshake, with per-word parity, framing and overrun status. It sits between the pad-side `dataline` and any byte/word consumer, and supersedes the fixed 8-bit receiver.

## Interface
- `DATA_W`, default 8: data bits per frame; legal range 5..9.
- `BAUD_W`, default 16: width of `baudrate`.
- `clk`  in  1: system clock; every register samples on the rising edge.
- `rst`  in  1: synchronous reset, active-high.
- `dataline`  in  1: serial line; idle high; asynchronous to `clk`.
- `baudrate`  in  BAUD_W: clocks per bit, N; values below 4 are treated as 4.
- `parity_mode`  in  2: 00 none, 01 even, 10 odd, 11 none.
- `stop2`  in  1: 1 selects two stop bits, 0 selects one.
- `data`  out  DATA_W: received word, LSB first on the line.
- `valid`  out  1: `data` and status flags are valid.
- `ready`  in  1: consumer accepts the word when `valid && ready`.
- `parity_err`  out  1: parity mismatch for the word now presented.
- `frame_err`  out  1: a stop bit was sampled low for the word now presented.
- `overrun`  out  1: sticky; a frame completed while `valid` was high.
- `busy`  out  1: FSM is not in IDLE.

## Operation
- `dataline` passes through a 2-flop synchroniser; the FSM only sees the synchronised line, `rxs`.
- States and transitions:
  - IDLE: on `rxs` = 0, go to START. Latch `baudrate`, `parity_mode` and `stop2`, which are frozen for the frame. Clear the bit counter.
  - START: at H = floor(N/2) cycles, sample the line. If it reads 1, this is a false start: return to IDLE with no output. If it reads 0, go to DATA.
  - DATA: DATA_W samples, N cycles apart, shifted in LSB first. Then go to PARITY if parity is enabled, otherwise to STOP.
  - PARITY: one sample. Even mode: error if the XOR of the data bits and the parity bit is 1. Odd mode: error if that XOR is 0.
  - STOP: one or two samples. If any stop sample is 0, `frame_err` is set. After the last stop sample, go to IDLE immediately, i.e. mid-bit.
- Completion when `valid` = 0: load `data`, `parity_err` and `frame_err`, and set `valid`.
- Completion when `valid` = 1: drop the new frame, keep the old word and set `overrun`.
- On `valid && ready`: `valid` clears next cycle and `overrun` clears. A completion in the same cycle as an accept loads the new word and keeps `valid` = 1 without setting `overrun`.
- Reset mid-frame: the partial frame is discarded.
- Reset values: `data` = 0, `valid` = 0, `parity_err` = 0, `frame_err` = 0, `overrun` = 0, `busy` = 0, state = IDLE, synchroniser flops = 1.

## Timing
- Let e be the edge at which synchroniser stage 1 first captures 0. IDLE leaves at edge e+2.
- Start sample at e+2+H. Sample k (k = 1..F) at e+2+H+k·N, where F = DATA_W + P + S, P ∈ {0,1} and S ∈ {1,2}.
- `valid` and the flags are visible after edge e+2+H+F·N.
- Example, the default frame: N = 8, DATA_W = 8, even parity, one stop bit, F = 10. `valid` rises 86 cycles after e.
- Back-to-back frames: a start edge arriving any time after the last stop sample is detected with no lost cycles.
- `busy` is high from e+2 through the last stop-sample edge inclusive.

## Configuration
- `UART_RX_MAJORITY_EN` defined: every bit is sampled at offsets −1, 0 and +1 around the nominal sample edge, and the 2-of-3 majority is used. The decision is still effective at the nominal edge plus 1, so all later timing shifts by +1 cycle. N ≥ 4 is required, which the clamp guarantees.
- Undefined: a single sample at the nominal edge, with the timing exactly as above.

## Structure
- Package `uart_pkg`:
  - `parity_e` enum: NONE, EVEN, ODD.
  - `rx_state_e` enum: IDLE, START, DATA, PARITY, STOP.
  - Constant `UART_MIN_BAUD` = 4.
- Sub-module `uart_baud_gen`:
  - Clocks-per-bit down-counter with a half-period preload on start.
  - Emits a one-cycle `sample_tick`, plus `pre_tick`/`post_tick` when `UART_RX_MAJORITY_EN` is defined.
- The FSM, shift register, parity and handshake logic live in `uart_rx_param`.

## Test plan
- Even parity, basic frame: N = 8, even parity, one stop bit, `ready` = 1. Send 0x55 (parity bit 0) → `data` = 0x55, `parity_err` = 0, `frame_err` = 0; `valid` high for one cycle, 86 cycles after e.
- Back-to-back frames: send 0x55 with the parity bit forced to 1, then 0x0F with parity bit 0, back-to-back → first word `parity_err` = 1, second word 0x0F with `parity_err` = 0.
- Odd parity, two stop bits, width 7: `parity_mode` = 10, `stop2` = 1, DATA_W = 7. Send 0x41 with parity bit 1 → no errors. Send it again with the second stop bit low → `frame_err` = 1.
- False start: a 3-cycle low glitch on `dataline` with N = 8 → no `valid`; `busy` falls back to 0 at the start-sample edge.
- Overrun: `ready` = 0, send 0xA5 then 0x3C → `data` stays 0xA5 and `overrun` = 1. Assert `ready` → `valid` and `overrun` clear next cycle.
- Reset and clamp: assert `rst` in the middle of the data bits → all outputs return to reset values and no word is emitted. Then with N = 2, a frame is received using an effective N = 4.
